balance_seq: RTL
================

// Module: balance_seq
// PURPOSE
//  Top-level sequencer for the balance PID datapath. Tracks power-button, rider
//  presence (load cells) and tilt faults, and drives the PID controls
//  pwr_up/rider_off/pid_vld. Asserts en_steer once the rider has stood evenly
//  for the settle time. Sits between the inertial/load-cell front end and PID.
// PARAMETERS
//  MIN_RIDER_WT  13'h0200  rider-present threshold on lft_ld+rght_ld
//  WT_HYST       13'h0040  hysteresis about MIN_RIDER_WT
//  FAST_SIM      1         1: settle timer 15 bits; 0: 26 bits (~1.34 s @50 MHz)
//  PTCH_LIM      16'h0800  |ptch| limit for tilt fault
//  FAULT_CNT     4'd8      consecutive over-limit vld samples -> FAULT
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous active-high reset
//  pwr_btn    in   1   1-clk pulse from debounced power button
//  vld        in   1   new inertial sample (ptch valid), 1-clk pulse
//  ptch       in   16  signed pitch
//  lft_ld     in   12  left load cell, unsigned
//  rght_ld    in   12  right load cell, unsigned
//  pwr_up     out  1   PID/soft-start enable (registered)
//  rider_off  out  1   PID integrator clear (registered)
//  pid_vld    out  1   vld & pwr_up (combinational gate, 0 latency)
//  en_steer   out  1   steering enable (registered)
//  fault      out  1   tilt fault latched (registered)
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
//  Reset: state=OFF, pwr_up=0, rider_off=1, en_steer=0, fault=0, tmr=0, fcnt=0.
//  sum = lft_ld+rght_ld (13 b); diff = |lft_ld-rght_ld| (12 b); no truncation.
//  ON_TH = MIN_RIDER_WT+WT_HYST; OFF_TH = MIN_RIDER_WT-WT_HYST.
//  States (registered outputs follow state one clk after transition):
//   OFF:    pwr_up=0,rider_off=1. pwr_btn -> IDLE.
//   IDLE:   pwr_up=1,rider_off=1. sum>ON_TH -> SETTLE (tmr cleared).
//   SETTLE: pwr_up=1,rider_off=0. sum<OFF_TH -> IDLE. diff>sum/4 -> clear tmr.
//           Otherwise tmr++. tmr all-ones -> STEER.
//   STEER:  en_steer=1. sum<OFF_TH -> IDLE. diff>sum/2 -> SETTLE (tmr cleared).
//   FAULT:  pwr_up=0,rider_off=1,fault=1. pwr_btn -> OFF (fault clears).
//  pwr_btn in IDLE/SETTLE/STEER -> OFF. This beats every other transition and
//  tmr is cleared.
//  Equality with a threshold does not trigger a transition (strict compares).
//  tmr saturates, never wraps; cleared on entering any state except STEER.
//  Reset mid-operation: full return to reset values on the next edge.
// CONFIGURATION
//  TILT_FAULT_EN defined:
//   On each vld in IDLE/SETTLE/STEER: fcnt++ if |ptch|>PTCH_LIM, else fcnt=0.
//   When fcnt reaches FAULT_CNT -> FAULT.
//   Fault beats rider transitions but not pwr_btn. |16'h8000| is treated as 16'h8000.
//  Not defined: fcnt logic absent, FAULT unreachable, fault tied 0.
// STRUCTURE
//  balance_pkg: state enum (OFF,IDLE,SETTLE,STEER,FAULT), default thresholds,
//   tmr width function of FAST_SIM.
//  Sub-module settle_tmr: clr/en inputs, saturating counter, full output.
//  FSM and threshold compares stay in balance_seq.
// TESTING
//  1 rst; pwr_btn -> pwr_up=1,rider_off=1 next clk; pid_vld mirrors vld.
//  2 lft=rght=12'h180 (sum 13'h300>ON_TH) -> SETTLE, rider_off=0.
//    Hold 2^15 clks (FAST_SIM) -> en_steer=1.
//  3 In SETTLE set lft=12'h300,rght=12'h010 (diff>sum/4) -> tmr restarts;
//    en_steer delayed a full 2^15 clks from rebalance.
//  4 In STEER drop sum to 13'h1B0 (<OFF_TH) -> IDLE, en_steer=0, rider_off=1.
//    Sum 13'h1C0 (=OFF_TH) -> stays.
//  5 TILT_FAULT_EN: 8 vld with ptch=16'h0900 -> FAULT, pwr_up=0, fault=1.
//    7 then ptch=0 -> no fault.
//  6 pwr_btn on same clk as tmr full in SETTLE -> OFF, en_steer stays 0.
//    rst mid-STEER -> reset values.

Source files
------------

// File: rtl/balance_pkg.sv
// Package: balance_pkg
// Shared types and defaults for the balance sequencer slice.
//  state_e     - sequencer states OFF, IDLE, SETTLE, STEER, FAULT
//  seq_out_t   - registered sequencer outputs, with its reset value
//  *_DEF       - default thresholds and limits
//  tmr_width() - settle timer width for the FAST_SIM setting
package balance_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    IDLE   = 3'd1,
    SETTLE = 3'd2,
    STEER  = 3'd3,
    FAULT  = 3'd4
  } state_e;

  typedef struct packed {
    logic pwr_up;
    logic rider_off;
    logic en_steer;
    logic fault;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{pwr_up: 1'b0, rider_off: 1'b1,
                                   en_steer: 1'b0, fault: 1'b0};

  localparam logic [12:0] MIN_RIDER_WT_DEF = 13'h0200;
  localparam logic [12:0] WT_HYST_DEF      = 13'h0040;
  localparam logic [15:0] PTCH_LIM_DEF     = 16'h0800;
  localparam logic [3:0]  FAULT_CNT_DEF    = 4'd8;

  // 15 bits keeps simulation short; 26 bits is ~1.34 s at 50 MHz.
  function automatic int unsigned tmr_width(input bit fast_sim);
    return fast_sim ? 32'd15 : 32'd26;
  endfunction

endpackage

// File: rtl/balance_seq_if.sv
// Interface: balance_seq_if
// Groups the sequencer's sensor inputs and PID control outputs.
//  pwr_btn   1-clk pulse from the debounced power button
//  vld       new inertial sample strobe (ptch valid)
//  ptch      signed pitch
//  lft_ld    left load cell, unsigned
//  rght_ld   right load cell, unsigned
//  pwr_up    PID/soft-start enable
//  rider_off PID integrator clear
//  pid_vld   vld gated by pwr_up
//  en_steer  steering enable
//  fault     tilt fault latched
// Modports: master drives the sensor side, slave is the sequencer.
interface balance_seq_if;
  logic        pwr_btn;
  logic        vld;
  logic [15:0] ptch;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        pwr_up;
  logic        rider_off;
  logic        pid_vld;
  logic        en_steer;
  logic        fault;

  modport master (
    output pwr_btn, vld, ptch, lft_ld, rght_ld,
    input  pwr_up, rider_off, pid_vld, en_steer, fault
  );

  modport slave (
    input  pwr_btn, vld, ptch, lft_ld, rght_ld,
    output pwr_up, rider_off, pid_vld, en_steer, fault
  );
endinterface

// File: rtl/balance_seq_settle_tmr.sv
// Module: settle_tmr
// Saturating settle timer; holds at all-ones instead of wrapping.
//  clk     system clock
//  rst     synchronous active-high reset (clears the count)
//  clr_i   clear the count (wins over en_i)
//  en_i    advance the count by one
//  full_o  count is all-ones
module settle_tmr #(
  parameter int unsigned W = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic full_o
);

  logic [W-1:0] tmr_q, tmr_d;

  assign full_o = &tmr_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tmr_d = tmr_q;
    if (clr_i)
      tmr_d = '0;
    else if (en_i && !full_o)
      tmr_d = tmr_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end

endmodule

// File: rtl/balance_seq.sv
// Module: balance_seq
// Sequencer for the balance PID datapath. Tracks the power button, rider
// presence from the load cells and (optionally) tilt faults, and drives the
// PID controls. en_steer rises once the rider has stood evenly for the
// settle time.
// Ports:
//  clk  system clock
//  rst  synchronous active-high reset
//  bus  balance_seq_if.slave: pwr_btn, vld, ptch, lft_ld, rght_ld in;
//       pwr_up, rider_off, pid_vld, en_steer, fault out
// Build option: define TILT_FAULT_EN to enable the tilt fault counter and the
// FAULT state; without it fault is constant 0.
module balance_seq
  import balance_pkg::*;
#(
  parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [12:0] WT_HYST      = WT_HYST_DEF,
  parameter bit          FAST_SIM     = 1'b1,
  parameter logic [15:0] PTCH_LIM     = PTCH_LIM_DEF,
  parameter logic [3:0]  FAULT_CNT    = FAULT_CNT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  balance_seq_if.slave  bus
);

  localparam logic [12:0] ON_TH  = MIN_RIDER_WT + WT_HYST;
  localparam logic [12:0] OFF_TH = MIN_RIDER_WT - WT_HYST;
  localparam int unsigned TMR_W  = tmr_width(FAST_SIM);

  state_e   state_q, state_d;
  seq_out_t out_q, out_d;

  logic [12:0] sum;
  logic [11:0] diff;
  logic        sum_gt_on, sum_lt_off, imbal_q4, imbal_q2;
  logic        active, tilt_hit;
  logic        tmr_clr, tmr_en, tmr_full;

  // Rider load: full-width sum and absolute difference, strict compares.
  assign sum        = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
  assign diff       = (bus.lft_ld >= bus.rght_ld) ? bus.lft_ld - bus.rght_ld
                                                  : bus.rght_ld - bus.lft_ld;
  assign sum_gt_on  = sum > ON_TH;
  assign sum_lt_off = sum < OFF_TH;
  assign imbal_q4   = {1'b0, diff} > (sum >> 2);
  assign imbal_q2   = {1'b0, diff} > (sum >> 1);

  assign active = (state_q == IDLE) || (state_q == SETTLE) || (state_q == STEER);

`ifdef TILT_FAULT_EN
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] ptch_abs;
  logic        over_lim;

  // -16'h8000 wraps back to 16'h8000, which is the intended magnitude.
  assign ptch_abs = bus.ptch[15] ? 16'(-bus.ptch) : bus.ptch;
  assign over_lim = ptch_abs > PTCH_LIM;
  // Fault fires on the sample that brings the run length to FAULT_CNT.
  assign tilt_hit = active && bus.vld && over_lim &&
                    ((5'(fcnt_q) + 5'd1) >= 5'(FAULT_CNT));

  always_comb begin
    fcnt_d = fcnt_q;
    if (!active)
      fcnt_d = '0;
    else if (bus.vld)
      fcnt_d = over_lim ? ((fcnt_q == 4'hF) ? fcnt_q : fcnt_q + 4'd1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end
`else
  logic unused_ptch;
  assign unused_ptch = ^bus.ptch;
  assign tilt_hit    = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next state. Priority: pwr_btn > tilt fault > rider transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (bus.pwr_btn) state_d = IDLE;
      IDLE:    if (sum_gt_on) state_d = SETTLE;
      SETTLE: begin
        if (sum_lt_off)                state_d = IDLE;
        else if (!imbal_q4 && tmr_full) state_d = STEER;
      end
      STEER: begin
        if (sum_lt_off)    state_d = IDLE;
        else if (imbal_q2) state_d = SETTLE;
      end
      FAULT:   if (bus.pwr_btn) state_d = OFF;
      default: state_d = OFF;
    endcase
    if (tilt_hit)              state_d = FAULT;
    if (active && bus.pwr_btn) state_d = OFF;
  end

  // Output decode from the current state; registered above.
  always_comb begin
    out_d = OUT_RST;
    case (state_q)
      IDLE:   out_d = '{pwr_up: 1'b1, rider_off: 1'b1, en_steer: 1'b0, fault: 1'b0};
      SETTLE: out_d = '{pwr_up: 1'b1, rider_off: 1'b0, en_steer: 1'b0, fault: 1'b0};
      STEER:  out_d = '{pwr_up: 1'b1, rider_off: 1'b0, en_steer: 1'b1, fault: 1'b0};
`ifdef TILT_FAULT_EN
      FAULT:  out_d = '{pwr_up: 1'b0, rider_off: 1'b1, en_steer: 1'b0, fault: 1'b1};
`endif
      default: out_d = OUT_RST;
    endcase
  end

  // Timer restarts on entry to any state but STEER, and whenever the rider
  // is uneven while settling; it only counts while staying in SETTLE.
  assign tmr_clr = ((state_d != state_q) && (state_d != STEER)) ||
                   ((state_q == SETTLE) && (state_d == SETTLE) && imbal_q4);
  assign tmr_en  = (state_q == SETTLE) && (state_d == SETTLE) && !imbal_q4;

  settle_tmr #(.W(TMR_W)) u_settle_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .full_o (tmr_full)
  );

  assign bus.pwr_up    = out_q.pwr_up;
  assign bus.rider_off = out_q.rider_off;
  assign bus.en_steer  = out_q.en_steer;
  assign bus.fault     = out_q.fault;
  assign bus.pid_vld   = bus.vld & out_q.pwr_up;

endmodule
